// File: rtl/immgen_pipe.sv
// Two-stage elastic immediate generator: S1 latches inst/pc/fmt,
// S2 latches the extended immediate, branch/jump target and status.
module immgen_pipe #(
  parameter int XLEN     = 32,
  parameter bit RV64I_EN = 1'b0
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            flush_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [31:0]     inst_i,
  input  logic [XLEN-1:0] pc_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [XLEN-1:0] imm_o,
  output logic [XLEN-1:0] tgt_o,
  output logic [2:0]      fmt_o,
  output logic            illegal_o
);

  localparam logic [2:0] F_NONE = 3'd0;
  localparam logic [2:0] F_I    = 3'd1;
  localparam logic [2:0] F_S    = 3'd2;
  localparam logic [2:0] F_B    = 3'd3;
  localparam logic [2:0] F_U    = 3'd4;
  localparam logic [2:0] F_J    = 3'd5;
  localparam logic [2:0] F_Z    = 3'd6;
  localparam logic [2:0] F_SH   = 3'd7;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_IMM32  = 7'b0011011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef struct packed {
    logic [31:0]     inst;
    logic [XLEN-1:0] pc;
    logic [2:0]      fmt;
  } s1_t;

  s1_t             s1_q;
  logic            s1_valid;
  logic            s2_valid;
  logic            s1_move;
  logic [2:0]      fmt_d;
  logic [XLEN-1:0] imm_d;
  logic [XLEN-1:0] tgt_d;
  logic            illegal_d;
  logic            shift_f3;

  assign s1_move     = ~s2_valid | out_ready_i;
  assign in_ready_o  = rst_ni & ~flush_i & (~s1_valid | s1_move);
  assign out_valid_o = s2_valid;
  assign shift_f3    = (inst_i[13:12] == 2'b01);

  always_comb begin
    fmt_d = F_NONE;
    unique case (inst_i[6:0])
      OP_LOAD, OP_JALR:  fmt_d = F_I;
      OP_IMM:            fmt_d = shift_f3 ? F_SH : F_I;
      OP_IMM32: begin
        if (RV64I_EN) fmt_d = shift_f3 ? F_SH : F_I;
      end
      OP_STORE:          fmt_d = F_S;
      OP_BRANCH:         fmt_d = F_B;
      OP_JAL:            fmt_d = F_J;
      OP_LUI, OP_AUIPC:  fmt_d = F_U;
      OP_SYSTEM:         fmt_d = inst_i[14] ? F_Z : F_NONE;
      default:           fmt_d = F_NONE;
    endcase
  end

  always_comb begin
    imm_d = '0;
    unique case (s1_q.fmt)
      F_I:  imm_d = XLEN'($signed(s1_q.inst[31:20]));
      F_S:  imm_d = XLEN'($signed({s1_q.inst[31:25], s1_q.inst[11:7]}));
      F_B:  imm_d = XLEN'($signed({s1_q.inst[31], s1_q.inst[7],
                                   s1_q.inst[30:25], s1_q.inst[11:8],
                                   1'b0}));
      F_U:  imm_d = XLEN'($signed({s1_q.inst[31:12], 12'b0}));
      F_J:  imm_d = XLEN'($signed({s1_q.inst[31], s1_q.inst[19:12],
                                   s1_q.inst[20], s1_q.inst[30:21],
                                   1'b0}));
      F_Z:  imm_d = XLEN'(s1_q.inst[19:15]);
      F_SH: begin
        // 6-bit shamt only for the full-width OP-IMM on RV64
        if (XLEN == 64 && s1_q.inst[6:0] == OP_IMM)
          imm_d = XLEN'(s1_q.inst[25:20]);
        else
          imm_d = XLEN'(s1_q.inst[24:20]);
      end
      default: imm_d = '0;
    endcase
  end

  assign tgt_d     = s1_q.pc + imm_d;
  assign illegal_d = (s1_q.fmt == F_NONE) &&
                     (s1_q.inst[6:0] != OP_SYSTEM);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_valid <= 1'b0;
      s1_q     <= '0;
    end else if (flush_i) begin
      s1_valid <= 1'b0;
    end else if (in_ready_o) begin
      s1_valid <= in_valid_i;
      if (in_valid_i) begin
        s1_q.inst <= inst_i;
        s1_q.pc   <= pc_i;
        s1_q.fmt  <= fmt_d;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s2_valid  <= 1'b0;
      imm_o     <= '0;
      tgt_o     <= '0;
      fmt_o     <= F_NONE;
      illegal_o <= 1'b0;
    end else if (flush_i) begin
      s2_valid <= 1'b0;
    end else if (s1_move) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        imm_o     <= imm_d;
        tgt_o     <= tgt_d;
        fmt_o     <= s1_q.fmt;
        illegal_o <= illegal_d;
      end
    end
  end

endmodule

// File: tb/tb_immgen_pipe.sv
// Bench for immgen_pipe: directed vectors plus a random stream
// scored against a field-arithmetic reference model.
module tb_immgen_pipe;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] inst;
  logic [31:0] pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] imm;
  logic [31:0] tgt;
  logic [2:0]  fmt;
  logic        illegal;

  int passed = 0;
  int total  = 0;

  typedef struct {
    logic [31:0] imm;
    logic [31:0] tgt;
    logic [2:0]  fmt;
    logic        ill;
  } exp_t;

  exp_t q[$];

  immgen_pipe #(.XLEN(32), .RV64I_EN(1'b0)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .flush_i     (flush),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .inst_i      (inst),
    .pc_i        (pc),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .imm_o       (imm),
    .tgt_o       (tgt),
    .fmt_o       (fmt),
    .illegal_o   (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic longint sx(input longint x, input int n);
    if (x >= (longint'(1) << (n - 1))) return x - (longint'(1) << n);
    return x;
  endfunction

  function automatic exp_t model(input logic [31:0] w,
                                 input logic [31:0] p);
    exp_t   e;
    longint v;
    int     f;
    bit     il;
    v = 0; f = 0; il = 0;
    case (w[6:0])
      7'h03, 7'h67: begin f = 1; v = sx(w[31:20], 12); end
      7'h13: begin
        if (w[14:12] == 3'd1 || w[14:12] == 3'd5) begin
          f = 7; v = w[24:20];
        end else begin
          f = 1; v = sx(w[31:20], 12);
        end
      end
      7'h23: begin f = 2; v = sx(w[31:25] * 32 + w[11:7], 12); end
      7'h63: begin
        f = 3;
        v = sx(w[31] * 4096 + w[7] * 2048 + w[30:25] * 32
               + w[11:8] * 2, 13);
      end
      7'h6F: begin
        f = 5;
        v = sx(w[31] * (1 << 20) + w[19:12] * (1 << 12)
               + w[20] * (1 << 11) + w[30:21] * 2, 21);
      end
      7'h37, 7'h17: begin f = 4; v = sx(longint'(w[31:12]) * 4096, 32); end
      7'h73: begin
        if (w[14]) begin f = 6; v = w[19:15]; end
        else f = 0;
      end
      default: il = 1;
    endcase
    e.imm = v[31:0];
    e.tgt = p + v[31:0];
    e.fmt = f[2:0];
    e.ill = il;
    return e;
  endfunction

  function automatic logic [31:0] gen_inst();
    logic [31:0] w;
    w = $urandom;
    case ($urandom_range(0, 11))
      0:  w[6:0] = 7'h03;
      1:  w[6:0] = 7'h67;
      2:  w[6:0] = 7'h13;
      3:  w[6:0] = 7'h1B;
      4:  w[6:0] = 7'h23;
      5:  w[6:0] = 7'h63;
      6:  w[6:0] = 7'h6F;
      7:  w[6:0] = 7'h37;
      8:  w[6:0] = 7'h17;
      9:  w[6:0] = 7'h73;
      10: w[6:0] = 7'h13;
      default: ;
    endcase
    return w;
  endfunction

  // one cycle: drive at negedge, score just after, advance to next negedge
  task automatic step(input bit iv, input logic [31:0] w,
                      input logic [31:0] p, input bit ordy,
                      input bit fl, output bit acc);
    in_valid  = iv;
    inst      = w;
    pc        = p;
    out_ready = ordy;
    flush     = fl;
    #1;
    acc = iv && in_ready && !fl;
    if (fl) check("flush_in_ready", in_ready, 0);
    if (out_valid) begin
      if (q.size() == 0) begin
        check("spurious_out", out_valid, 0);
      end else begin
        check("imm", imm, q[0].imm);
        check("tgt", tgt, q[0].tgt);
        check("fmt", fmt, q[0].fmt);
        check("ill", illegal, q[0].ill);
        if (ordy && !fl) void'(q.pop_front());
      end
    end
    if (acc) q.push_back(model(w, p));
    if (fl) q.delete();
    @(negedge clk);
  endtask

  task automatic single(input logic [31:0] w, input logic [31:0] p);
    bit acc;
    step(1, w, p, 1, 0, acc);
    check("accept", acc, 1);
    check("lat1_valid", out_valid, 0);
    step(0, 0, 0, 1, 0, acc);
    check("lat2_valid", out_valid, 1);
  endtask

  initial begin
    bit acc;
    logic [31:0] ws[4];
    int sent;
    rst_n = 0; flush = 0; in_valid = 0; out_ready = 0;
    inst = 0; pc = 0;
    #3;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_imm", imm, 0);
    check("rst_tgt", tgt, 0);
    check("rst_fmt", fmt, 0);
    check("rst_ill", illegal, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
    #1;
    check("rst_release_ready", in_ready, 1);
    @(negedge clk);

    single(32'hFFF03093, 32'h0);
    check("sltiu_imm", imm, 32'hFFFFFFFF);
    check("sltiu_fmt", fmt, 1);
    check("sltiu_ill", illegal, 0);
    step(0, 0, 0, 1, 0, acc);

    single(32'hFE000EE3, 32'h100);
    check("beq_imm", imm, 32'hFFFFFFFC);
    check("beq_tgt", tgt, 32'h000000FC);
    check("beq_fmt", fmt, 3);
    step(0, 0, 0, 1, 0, acc);

    single(32'hFF9FF06F, 32'h4);
    check("jal_imm", imm, 32'hFFFFFFF8);
    check("jal_tgt", tgt, 32'hFFFFFFFC);
    check("jal_fmt", fmt, 5);
    step(0, 0, 0, 1, 0, acc);

    single(32'h00000000, 32'h40);
    check("zero_ill", illegal, 1);
    check("zero_fmt", fmt, 0);
    check("zero_imm", imm, 0);
    step(0, 0, 0, 1, 0, acc);

    single(32'h0002D073, 32'h80);
    check("csrrwi_imm", imm, 32'h5);
    check("csrrwi_fmt", fmt, 6);
    step(0, 0, 0, 1, 0, acc);

    // backpressure: consumer stalls 3 cycles while 4 are offered
    for (int i = 0; i < 4; i++) ws[i] = gen_inst();
    sent = 0;
    for (int c = 0; c < 20 && sent < 4; c++) begin
      step(1, ws[sent], 32'h1000 + 4 * sent, c >= 3, 0, acc);
      if (acc) sent++;
      if (c == 1) check("stall_in_ready", in_ready, 0);
    end
    check("stall_sent", sent, 4);
    for (int c = 0; c < 4; c++) step(0, 0, 0, 1, 0, acc);
    check("stall_drained", q.size(), 0);

    // flush with both stages full
    step(1, gen_inst(), 32'h2000, 0, 0, acc);
    step(1, gen_inst(), 32'h2004, 0, 0, acc);
    check("full_out_valid", out_valid, 1);
    step(1, gen_inst(), 32'h2008, 1, 1, acc);
    check("flush_out_valid", out_valid, 0);
    step(0, 0, 0, 1, 0, acc);
    check("flush_discard", out_valid, 0);
    single(32'hFE000EE3, 32'h100);
    check("post_flush_tgt", tgt, 32'h000000FC);
    step(0, 0, 0, 1, 0, acc);

    // asynchronous reset mid-stream
    step(1, gen_inst(), 32'h3000, 0, 0, acc);
    step(1, gen_inst(), 32'h3004, 0, 0, acc);
    in_valid = 0;
    #2;
    rst_n = 0;
    #1;
    check("async_out_valid", out_valid, 0);
    check("async_in_ready", in_ready, 0);
    check("async_imm", imm, 0);
    check("async_fmt", fmt, 0);
    q.delete();
    @(negedge clk);
    rst_n = 1;
    #1;
    check("rerst_ready", in_ready, 1);
    @(negedge clk);
    single(32'hFF9FF06F, 32'h4);
    check("post_rst_tgt", tgt, 32'hFFFFFFFC);
    step(0, 0, 0, 1, 0, acc);

    // random stream with backpressure and occasional flushes
    for (int c = 0; c < 400; c++) begin
      step(($urandom % 4) != 0, gen_inst(), $urandom,
           ($urandom % 3) != 0, ($urandom % 40) == 0, acc);
    end
    for (int c = 0; c < 4; c++) step(0, 0, 0, 1, 0, acc);
    check("rand_drained", q.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/immgen_pipe.md
IMMGEN_PIPE -- requirements
Module: immgen_pipe

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, meaning the immediate/PC datapath width; the legal values are 32 and 64.
REQ-002 The block SHALL have parameter RV64I_EN, default 0, meaning that when it is 1, opcode 0011011 (OP-IMM-32) is decoded; it SHALL be 1 only when XLEN=64.
REQ-003 clk_i  input  1  SHALL be the single clock; all state updates on the rising edge.
REQ-004 rst_ni  input  1  SHALL be the reset, asynchronous and active-low.
REQ-005 flush_i  input  1  SHALL be a synchronous pipeline kill.
REQ-006 in_valid_i  input  1  SHALL indicate that inst_i/pc_i are valid.
REQ-007 in_ready_o  output  1  SHALL indicate that the block accepts an input this cycle.
REQ-008 inst_i  input  32  SHALL carry the instruction word.
REQ-009 pc_i  input  XLEN  SHALL carry the PC of inst_i.
REQ-010 out_valid_o  output  1  SHALL indicate that the result is valid.
REQ-011 out_ready_i  input  1  SHALL indicate that the consumer accepts the result.
REQ-012 imm_o  output  XLEN  SHALL carry the extended immediate.
REQ-013 tgt_o  output  XLEN  SHALL carry pc + imm.
REQ-014 fmt_o  output  3  SHALL carry the format code: 0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 Z (CSR zimm), 7 SH (shift amount).
REQ-015 illegal_o  output  1  SHALL flag an undecodable opcode.

Function
REQ-016 The block SHALL be a 2-stage elastic pipeline: S1 registers inst, pc, and fmt; S2 registers imm_o, tgt_o, fmt_o, and illegal_o.
REQ-017 Latency SHALL be 2 cycles from an accepted input to out_valid_o when out_ready_i is held high; throughput SHALL be 1 per cycle.
REQ-018 A transfer SHALL occur only when valid and ready are both high on the same edge, for both the input side and the output side.
REQ-019 Stage k SHALL load when it is empty or when its contents move downstream in the same cycle; in_ready_o = ~s1_valid | s1_move, where s1_move = s2 empty | (out_valid_o & out_ready_i), and in_ready_o SHALL be 0 while flush_i=1.
REQ-020 While out_valid_o=1 and out_ready_i=0, all outputs SHALL hold stable, and no instruction SHALL be lost or duplicated.
REQ-021 Opcode 0000011, 1100111, 0010011 (funct3 other than 001/101), and 0011011 when RV64I_EN=1 (funct3 other than 001/101) SHALL decode as I: sign-extended inst[31:20]; every I-type immediate, including SLTIU/ANDI/ORI/XORI, SHALL be sign-extended.
REQ-022 Opcode 0010011/0011011 with funct3 001/101 SHALL decode as SH: imm = zero-extended inst[24:20] when XLEN=32 or for opcode 0011011, and zero-extended inst[25:20] when XLEN=64 for opcode 0010011.
REQ-023 Opcode 0100011 SHALL decode as S: sign-extended {inst[31:25], inst[11:7]}.
REQ-024 Opcode 1100011 SHALL decode as B: sign-extended {inst[31], inst[7], inst[30:25], inst[11:8], 0}.
REQ-025 Opcode 1101111 SHALL decode as J: sign-extended {inst[31], inst[19:12], inst[20], inst[30:21], 0}.
REQ-026 Opcodes 0110111 and 0010111 SHALL decode as U: {inst[31:12], 12'b0}, sign-extended to XLEN.
REQ-027 Opcode 1110011 with funct3[2]=1 SHALL decode as Z: imm = zero-extended inst[19:15]; opcode 1110011 with funct3[2]=0 SHALL decode as NONE with illegal_o=0.
REQ-028 Any other opcode, or inst[1:0] != 11, SHALL produce fmt_o=0, imm_o=0, and illegal_o=1.
REQ-029 tgt_o SHALL equal pc + imm modulo 2^XLEN for every format, wrapping silently with no overflow flag.
REQ-030 flush_i=1 SHALL clear both stage valid bits at the next edge, so that out_valid_o=0 in the following cycle; an input presented during flush SHALL be discarded, and the flush SHALL override any simultaneous in_valid_i or out_ready_i.

Reset
REQ-031 While rst_ni=0, out_valid_o, the internal valid bits, and in_ready_o SHALL be 0, and imm_o, tgt_o, fmt_o, and illegal_o SHALL be 0; in_ready_o SHALL rise in the first cycle after rst_ni deasserts.
REQ-032 Reset asserted mid-operation SHALL drop all in-flight instructions immediately, without waiting for a clock edge.

Verification
REQ-033 inst 0xFFF03093 (SLTIU), pc 0x0, out_ready_i=1 -> 2 cycles later: out_valid_o=1, imm_o=0xFFFFFFFF, fmt_o=1, illegal_o=0.
REQ-034 inst 0xFE000EE3 (BEQ -4), pc 0x100 -> imm_o=0xFFFFFFFC, tgt_o=0x000000FC, fmt_o=3.
REQ-035 inst 0xFF9FF06F (JAL -8), pc 0x4 -> imm_o=0xFFFFFFF8, tgt_o=0xFFFFFFFC (wrap), fmt_o=5.
REQ-036 Issue 4 back-to-back instructions with out_ready_i=0 for 3 cycles -> in_ready_o=0 once 2 are held, outputs stable, then all 4 emerge in order, none lost.
REQ-037 inst 0x00000000 -> illegal_o=1, fmt_o=0, imm_o=0; inst 0x0002D073 (CSRRWI zimm=5) -> imm_o=0x5, fmt_o=6.
REQ-038 Flush with both stages full, and separately rst_ni pulsed low mid-stream -> out_valid_o=0 on the next cycle (immediately for reset), and the following input yields correct results with 2-cycle latency.
